// File: rtl/clock_ratio_pkg.sv
// Shared definitions for the multi-channel clock-ratio generator.
//   - ch_state_e        : per-channel FSM state (IDLE, RUN, STOPPING)
//   - MODE_PULSE/SQUARE : waveform selector values on the mode inputs
//   - ratio_width()     : ratio field width able to hold MAX_RATIO itself
//   - square_high_count(): number of high cycles per period in square mode
package clock_ratio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } ch_state_e;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  function automatic int ratio_width(input int max_ratio);
    return $clog2(max_ratio + 1);
  endfunction

  // ceil(r/2): odd ratios spend the extra cycle high (R=3 -> 2 high, 1 low)
  function automatic int unsigned square_high_count(input int unsigned r);
    return (r + 1) / 2;
  endfunction

endpackage

// File: rtl/clock_ratio_channel.sv
// One clock-ratio channel: FSM, period counter, shadow ratio/mode and a
// sticky illegal-ratio flag. Produces a registered gated waveform at clk_in/R.
// Ports:
//   clk_in, rst_n : clock and asynchronous active-low reset
//   enable        : run request (level)
//   ratio, mode   : requested ratio and waveform, sampled at period boundaries
//   clear_err     : one-cycle pulse clearing ratio_err
//   gated_clk     : registered gated waveform
//   tick          : one-cycle strobe at the start of each period
//   active        : channel is in RUN or STOPPING
//   ratio_err     : sticky illegal-ratio flag
module clock_ratio_channel
  import clock_ratio_pkg::*;
#(
  parameter int MAX_RATIO = 8,
  parameter int RW        = ratio_width(MAX_RATIO)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [RW-1:0] ratio,
  input  logic          mode,
  input  logic          clear_err,
  output logic          gated_clk,
  output logic          tick,
  output logic          active,
  output logic          ratio_err
);

  ch_state_e     state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] r_q, r_d;
  logic          mode_q, mode_d;
  logic          gated_q, gated_d;
  logic          tick_q, tick_d;
  logic          active_q, active_d;
  logic          err_q, err_d;
  logic          err_set;

  logic          ratio_legal;
  logic          at_end;
  logic [RW-1:0] cnt_inc;
  logic [RW-1:0] high_cnt;

  assign ratio_legal = (ratio != '0) && (ratio <= RW'(MAX_RATIO));
  // Shadow R is never 0 (reset value 1, only legal ratios load), so R-1 is safe
  assign at_end      = (cnt_q == (r_q - RW'(1)));
  assign cnt_inc     = at_end ? '0 : (cnt_q + RW'(1));

  // Next-state, counter and shadow-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    mode_d  = mode_q;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (ratio_legal) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            r_d     = ratio;
            mode_d  = mode;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (!enable) begin
          // Finish the current period before going idle
          state_d = at_end ? ST_IDLE : ST_STOPPING;
        end else if (at_end) begin
          // Period boundary: new ratio/mode take effect from the next period;
          // an illegal request keeps the old ratio running
          if (ratio_legal) begin
            r_d    = ratio;
            mode_d = mode;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_STOPPING: begin
        cnt_d = cnt_inc;
        if (enable) begin
          state_d = ST_RUN;  // resume without restarting the count
        end else if (at_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they are glitch-free flops
  always_comb begin
    high_cnt = RW'(square_high_count(32'(r_d)));
    gated_d  = 1'b0;
    tick_d   = 1'b0;
    active_d = (state_d != ST_IDLE);
    if (active_d) begin
      tick_d = (cnt_d == '0);
      unique case (mode_d)
        MODE_PULSE:  gated_d = (cnt_d == '0);
        MODE_SQUARE: gated_d = (cnt_d < high_cnt);
        default:     gated_d = 1'b0;
      endcase
    end
    // Set wins over a simultaneous clear
    err_d = err_set | (err_q & ~clear_err);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      r_q      <= RW'(1);
      mode_q   <= MODE_PULSE;
      gated_q  <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      mode_q   <= mode_d;
      gated_q  <= gated_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign gated_clk = gated_q;
  assign tick      = tick_q;
  assign active    = active_q;
  assign ratio_err = err_q;

endmodule

// File: rtl/clock_ratio_gen.sv
// Multi-channel clock-ratio generator: NUM_CH independent channels, each
// producing a gated clock-enable waveform at clk_in/R.
// Ports:
//   clk_in, rst_n : clock and asynchronous active-low reset
//   enable        : per-channel run request
//   ratio         : per-channel ratio, channel i at [i*RW +: RW]
//   mode          : per-channel waveform (0 pulse, 1 square)
//   clear_err     : clears every ratio_err bit
//   gated_clk, tick, active, ratio_err : per-channel outputs
module clock_ratio_gen
  import clock_ratio_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int MAX_RATIO = 8,
  localparam int RW        = ratio_width(MAX_RATIO)
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    enable,
  input  logic [NUM_CH*RW-1:0] ratio,
  input  logic [NUM_CH-1:0]    mode,
  input  logic                 clear_err,
  output logic [NUM_CH-1:0]    gated_clk,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    active,
  output logic [NUM_CH-1:0]    ratio_err
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clock_ratio_channel #(
      .MAX_RATIO(MAX_RATIO),
      .RW       (RW)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .enable   (enable[gi]),
      .ratio    (ratio[gi*RW +: RW]),
      .mode     (mode[gi]),
      .clear_err(clear_err),
      .gated_clk(gated_clk[gi]),
      .tick     (tick[gi]),
      .active   (active[gi]),
      .ratio_err(ratio_err[gi])
    );
  end

endmodule

// File: tb/tb_clock_ratio_gen.sv
module tb_clock_ratio_gen;

  localparam int NUM_CH    = 4;
  localparam int MAX_RATIO = 8;
  localparam int RW        = 4;

  logic                 clk_in = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_CH-1:0]    enable = '0;
  logic [NUM_CH*RW-1:0] ratio = '0;
  logic [NUM_CH-1:0]    mode = '0;
  logic                 clear_err = 1'b0;
  logic [NUM_CH-1:0]    gated_clk;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    active;
  logic [NUM_CH-1:0]    ratio_err;

  int checks = 0;
  int errors = 0;

  clock_ratio_gen #(
    .NUM_CH   (NUM_CH),
    .MAX_RATIO(MAX_RATIO)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .enable   (enable),
    .ratio    (ratio),
    .mode     (mode),
    .clear_err(clear_err),
    .gated_clk(gated_clk),
    .tick     (tick),
    .active   (active),
    .ratio_err(ratio_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic set_ratio(input int ch, input int r);
    ratio[ch*RW +: RW] = RW'(r);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({gated_clk, tick, active, ratio_err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0000", {gated_clk, tick, active, ratio_err});
    end
    rst_n = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({gated_clk, tick, active, ratio_err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0000", {gated_clk, tick, active, ratio_err});
    end
    $display("test_reset done");
  endtask

  // Ch0 ratio 4 pulse: high one cycle in four, first high right after enable
  task automatic test_pulse;
    logic e;
    set_ratio(0, 4);
    mode[0]   = 1'b0;
    enable[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      e = ((k % 4) == 0);
      checks++;
      if ({gated_clk[0], tick[0], active[0]} !== {e, e, 1'b1}) begin
        errors++;
        $display("FAIL pulse_ch0 k=%0d: g/t/a got %b expected %b", k,
                 {gated_clk[0], tick[0], active[0]}, {e, e, 1'b1});
      end
    end
    enable[0] = 1'b0;  // last read was cnt=3 -> straight to IDLE
    @(negedge clk_in);
    checks++;
    if ({gated_clk[0], tick[0], active[0]} !== 3'b000) begin
      errors++;
      $display("FAIL pulse_ch0_stop: g/t/a got %b expected 000", {gated_clk[0], tick[0], active[0]});
    end
    $display("test_pulse done");
  endtask

  // Ch1 ratio 3 square (1,1,0), ratio->2 mid-period takes effect at the boundary
  task automatic test_square_update;
    logic eg, et;
    logic [5:0] exp_g;
    logic [5:0] exp_t;
    exp_g = 6'b010101;  // bit j = read j after the change
    exp_t = 6'b010100;
    set_ratio(1, 3);
    mode[1]   = 1'b1;
    enable[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_in);
      eg = ((k % 3) < 2);
      et = ((k % 3) == 0);
      checks++;
      if ({gated_clk[1], tick[1], active[1]} !== {eg, et, 1'b1}) begin
        errors++;
        $display("FAIL square_ch1 k=%0d: g/t/a got %b expected %b", k,
                 {gated_clk[1], tick[1], active[1]}, {eg, et, 1'b1});
      end
    end
    set_ratio(1, 2);  // at cnt=0 of a 3-cycle period
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_in);
      checks++;
      if ({gated_clk[1], tick[1], active[1]} !== {exp_g[j], exp_t[j], 1'b1}) begin
        errors++;
        $display("FAIL square_ch1_update j=%0d: g/t/a got %b expected %b", j,
                 {gated_clk[1], tick[1], active[1]}, {exp_g[j], exp_t[j], 1'b1});
      end
    end
    enable[1] = 1'b0;  // last read was cnt=1 of R=2
    @(negedge clk_in);
    checks++;
    if ({gated_clk[1], tick[1], active[1]} !== 3'b000) begin
      errors++;
      $display("FAIL square_ch1_stop: g/t/a got %b expected 000", {gated_clk[1], tick[1], active[1]});
    end
    $display("test_square_update done");
  endtask

  // Ch2 ratio 5: graceful stop, then stop/resume without count restart
  task automatic test_stop;
    logic [2:0] exp_v [0:10];
    exp_v[0] = 3'b111; exp_v[1] = 3'b001;                     // cnt0, cnt1
    exp_v[2] = 3'b001; exp_v[3] = 3'b001; exp_v[4] = 3'b001;  // STOPPING cnt2..4
    exp_v[5] = 3'b000; exp_v[6] = 3'b000; exp_v[7] = 3'b000;  // IDLE, no runt
    set_ratio(2, 5);
    mode[2]   = 1'b0;
    enable[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      checks++;
      if ({gated_clk[2], tick[2], active[2]} !== exp_v[k]) begin
        errors++;
        $display("FAIL stop_ch2 k=%0d: g/t/a got %b expected %b", k,
                 {gated_clk[2], tick[2], active[2]}, exp_v[k]);
      end
      if (k == 1) enable[2] = 1'b0;
    end
    // Resume: drop at cnt1, re-enable at cnt2; period continues cnt3, cnt4, cnt0
    exp_v[0] = 3'b111; exp_v[1] = 3'b001; exp_v[2] = 3'b001;
    exp_v[3] = 3'b001; exp_v[4] = 3'b001; exp_v[5] = 3'b111;
    enable[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      checks++;
      if ({gated_clk[2], tick[2], active[2]} !== exp_v[k]) begin
        errors++;
        $display("FAIL resume_ch2 k=%0d: g/t/a got %b expected %b", k,
                 {gated_clk[2], tick[2], active[2]}, exp_v[k]);
      end
      if (k == 1) enable[2] = 1'b0;
      if (k == 2) enable[2] = 1'b1;
    end
    enable[2] = 1'b0;  // at cnt0: four more cycles then IDLE
    repeat (4) @(negedge clk_in);
    checks++;
    if (active[2] !== 1'b1) begin
      errors++;
      $display("FAIL stop_ch2_last: active got %b expected 1", active[2]);
    end
    @(negedge clk_in);
    checks++;
    if ({gated_clk[2], tick[2], active[2]} !== 3'b000) begin
      errors++;
      $display("FAIL stop_ch2_idle: g/t/a got %b expected 000", {gated_clk[2], tick[2], active[2]});
    end
    $display("test_stop done");
  endtask

  // Ch3 illegal ratios, clear priority, illegal ratio at a running boundary
  task automatic test_error;
    logic [3:0] exp_v [0:6];
    set_ratio(3, 0);
    mode[3]   = 1'b0;
    enable[3] = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ratio_err[3], active[3], gated_clk[3]} !== 3'b100) begin
      errors++;
      $display("FAIL err_ratio0: e/a/g got %b expected 100", {ratio_err[3], active[3], gated_clk[3]});
    end
    set_ratio(3, 9);
    clear_err = 1'b1;  // new error on the same edge must win
    @(negedge clk_in);
    clear_err = 1'b0;
    checks++;
    if ({ratio_err[3], active[3], gated_clk[3]} !== 3'b100) begin
      errors++;
      $display("FAIL err_ratio9_setwins: e/a/g got %b expected 100", {ratio_err[3], active[3], gated_clk[3]});
    end
    enable[3] = 1'b0;
    clear_err = 1'b1;
    @(negedge clk_in);
    clear_err = 1'b0;
    checks++;
    if (ratio_err[3] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: ratio_err got %b expected 0", ratio_err[3]);
    end
    // Running at R=2, request 9 mid-period: error at boundary, keeps R=2
    // {err, gated, tick, active}
    exp_v[0] = 4'b0111; exp_v[1] = 4'b0001; exp_v[2] = 4'b1111;
    exp_v[3] = 4'b1001; exp_v[4] = 4'b1111; exp_v[5] = 4'b1001;
    exp_v[6] = 4'b1000;
    set_ratio(3, 2);
    enable[3] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_in);
      checks++;
      if ({ratio_err[3], gated_clk[3], tick[3], active[3]} !== exp_v[k]) begin
        errors++;
        $display("FAIL err_boundary_ch3 k=%0d: e/g/t/a got %b expected %b", k,
                 {ratio_err[3], gated_clk[3], tick[3], active[3]}, exp_v[k]);
      end
      if (k == 0) set_ratio(3, 9);
      if (k == 4) enable[3] = 1'b0;
    end
    clear_err = 1'b1;
    @(negedge clk_in);
    clear_err = 1'b0;
    checks++;
    if (ratio_err !== 4'b0000) begin
      errors++;
      $display("FAIL err_clear_final: ratio_err got %b expected 0000", ratio_err);
    end
    $display("test_error done");
  endtask

  // R=1 in both modes: constant high and a tick every cycle
  task automatic test_ratio_one;
    set_ratio(0, 1);
    set_ratio(1, 1);
    mode[1:0]   = 2'b10;
    enable[1:0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      checks++;
      if ({gated_clk[1:0], tick[1:0], active[1:0]} !== 6'b111111) begin
        errors++;
        $display("FAIL ratio_one k=%0d: g/t/a got %b expected 111111", k,
                 {gated_clk[1:0], tick[1:0], active[1:0]});
      end
    end
    enable[1:0] = 2'b00;
    @(negedge clk_in);
    checks++;
    if ({gated_clk[1:0], tick[1:0], active[1:0]} !== 6'b000000) begin
      errors++;
      $display("FAIL ratio_one_stop: g/t/a got %b expected 000000",
               {gated_clk[1:0], tick[1:0], active[1:0]});
    end
    $display("test_ratio_one done");
  endtask

  // R=MAX_RATIO: ch2 square (4 high of 8), ch3 pulse
  task automatic test_max_ratio;
    logic g2, g3, t;
    set_ratio(2, MAX_RATIO);
    set_ratio(3, MAX_RATIO);
    mode[3:2]   = 2'b01;
    enable[3:2] = 2'b11;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      g2 = ((k % 8) < 4);
      g3 = ((k % 8) == 0);
      t  = g3;
      checks++;
      if ({gated_clk[3:2], tick[3:2], active[3:2]} !== {g3, g2, t, t, 2'b11}) begin
        errors++;
        $display("FAIL max_ratio k=%0d: g/t/a got %b expected %b", k,
                 {gated_clk[3:2], tick[3:2], active[3:2]}, {g3, g2, t, t, 2'b11});
      end
    end
    enable[3:2] = 2'b00;
    @(negedge clk_in);
    checks++;
    if (active[3:2] !== 2'b00) begin
      errors++;
      $display("FAIL max_ratio_stop: active got %b expected 00", active[3:2]);
    end
    $display("test_max_ratio done");
  endtask

  // All channels running, async reset off-edge, restart with enable held
  task automatic test_async_reset;
    mode = 4'b0000;
    set_ratio(0, 4);
    set_ratio(1, 3);
    set_ratio(2, 5);
    set_ratio(3, 0);  // sets ratio_err[3] so reset clearing it is visible
    enable = 4'hF;
    @(negedge clk_in);
    set_ratio(3, 2);
    repeat (6) @(negedge clk_in);
    checks++;
    if ({active, ratio_err[3]} !== 5'b11111) begin
      errors++;
      $display("FAIL async_pre: active/err3 got %b expected 11111", {active, ratio_err[3]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gated_clk, tick, active, ratio_err} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0000", {gated_clk, tick, active, ratio_err});
    end
    @(negedge clk_in);
    checks++;
    if ({gated_clk, tick, active, ratio_err} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_held: got %h expected 0000", {gated_clk, tick, active, ratio_err});
    end
    rst_n = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({gated_clk, tick, active, ratio_err} !== 16'hFFF0) begin
      errors++;
      $display("FAIL async_restart_c0: got %h expected fff0", {gated_clk, tick, active, ratio_err});
    end
    @(negedge clk_in);
    checks++;
    if ({gated_clk, tick, active, ratio_err} !== 16'h00F0) begin
      errors++;
      $display("FAIL async_restart_c1: got %h expected 00f0", {gated_clk, tick, active, ratio_err});
    end
    @(negedge clk_in);  // ch3 (R=2) wraps to cnt0, others at cnt2
    checks++;
    if ({gated_clk, tick, active} !== 12'h88F) begin
      errors++;
      $display("FAIL async_restart_c2: got %h expected 88f", {gated_clk, tick, active});
    end
    enable = 4'h0;
    repeat (8) @(negedge clk_in);
    checks++;
    if (active !== 4'h0) begin
      errors++;
      $display("FAIL async_final_idle: active got %b expected 0000", active);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_square_update();
    test_stop();
    test_error();
    test_ratio_one();
    test_max_ratio();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_ratio_gen.md
Name: clock_ratio_gen

Overview:
- Multi-channel, parametrised successor to the single-channel clock multiplier.
- Each channel produces a registered, glitch-free gated clock-enable waveform at clk_in/R, with R programmable per channel.
- Each channel has a pulse or square-wave mode, a period-boundary ratio update, graceful stop and illegal-ratio flagging.
- Sits between the clock-control registers and downstream strobe consumers; all outputs are synchronous to clk_in.

Parameters:
- NUM_CH, 4: number of independent channels.
- MAX_RATIO, 8: largest legal ratio. Per-channel ratio field width RW = $clog2(MAX_RATIO+1), so MAX_RATIO itself is representable.

Ports:
- clk_in  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  NUM_CH  per-channel run request, level-sensitive.
- ratio  input  NUM_CH*RW  per-channel requested ratio; channel i uses bits [i*RW +: RW].
- mode  input  NUM_CH  per-channel waveform: 0 = pulse, 1 = square.
- clear_err  input  1  one-cycle pulse that clears all ratio_err bits.
- gated_clk  output  NUM_CH  per-channel registered gated waveform.
- tick  output  NUM_CH  one-cycle strobe at the start of each period.
- active  output  NUM_CH  channel is in RUN or STOPPING.
- ratio_err  output  NUM_CH  sticky illegal-ratio flag.

Behaviour:
- Reset (async, rst_n=0):
  - Every channel goes to IDLE, cnt=0, shadow ratio R=1, shadow mode=0.
  - gated_clk, tick, active and ratio_err all go to 0 immediately, without waiting for a clock edge.
  - Reset asserted mid-period truncates the period; this is the only allowed truncation.
- Legal ratio: 1 <= ratio <= MAX_RATIO. Values 0 and values above MAX_RATIO are illegal.
- Per-channel FSM: IDLE, RUN, STOPPING.
  - IDLE -> RUN: enable=1 and ratio is legal. ratio and mode load into the shadow registers and cnt=0 on that edge.
  - IDLE, enable=1, illegal ratio: stay in IDLE and set ratio_err.
  - RUN -> STOPPING: enable=0 while cnt != R-1.
  - RUN -> IDLE: enable=0 while cnt == R-1.
  - STOPPING -> IDLE: when cnt reaches R-1. The period always completes, so there are no runt pulses.
  - STOPPING -> RUN: enable re-asserted. Counting continues with no restart.
- Counter:
  - In RUN and STOPPING, cnt increments modulo R.
  - At the boundary (cnt == R-1, state RUN, enable=1), ratio and mode are resampled into the shadow registers.
  - An illegal ratio at the boundary keeps the old shadow R, sets ratio_err, and the channel keeps running.
  - A mid-period ratio change has no effect until the next boundary.
- Outputs are registered and take their values from the next-state/next-cnt:
  - gated_clk, pulse mode: 1 while cnt == 0.
  - gated_clk, square mode: 1 while cnt < ceil(R/2). R=3 gives high for 2 cycles, low for 1.
  - R=1, either mode: gated_clk stays constantly 1 while active.
  - tick: 1 while cnt == 0 and active.
  - gated_clk and tick are 0 in IDLE.
- Latency: enable sampled 1 at edge E (IDLE, legal ratio) gives gated_clk=1 and tick=1 in the cycle following E.
- ratio_err: sticky.
  - clear_err clears it on the next edge.
  - If a new error occurs on the same edge as clear_err, the set wins.
- Channels are fully independent; there is no shared state beyond clear_err.

Decomposition:
- Package clock_ratio_pkg holds:
  - the state enum (IDLE, RUN, STOPPING);
  - the mode constants MODE_PULSE=0 and MODE_SQUARE=1;
  - a function computing RW from MAX_RATIO;
  - a function computing the square-wave high count ceil(R/2).
- Sub-module clock_ratio_channel (one FSM, counter, shadow registers and error flag) is instantiated NUM_CH times by a generate loop in clock_ratio_gen.

Test Plan:
- Ch0, ratio=4, mode=0, enable rises -> gated_clk[0] and tick[0] high 1 cycle in 4, first high the cycle after enable is sampled; active[0]=1.
- Ch1, ratio=3, mode=1 -> gated_clk[1] pattern 1,1,0 repeating. Change ratio to 2 mid-period -> the current 3-cycle period completes, then 1,0.
- Ch2 running at ratio=5, enable dropped at cnt=1 -> STOPPING; remaining cycles complete; IDLE after cnt=4; active[2] falls; no runt pulse.
- Ch3, ratio=0 then ratio=9 (MAX_RATIO=8) -> ratio_err[3]=1 and the channel stays in IDLE or at the old R. clear_err together with a fresh illegal ratio -> ratio_err stays 1. clear_err alone -> 0.
- All channels running, rst_n pulsed low off-edge -> all outputs 0 asynchronously. After release with enable held, restart at cnt=0 with R=requested ratio.
- ratio=1, both modes -> gated_clk constantly 1 and tick every cycle. Ratio=MAX_RATIO=8 -> period of 8 cycles; square mode high for 4.
